// File: rtl/tail_ptr_pkg.sv
// tail_ptr_pkg: shared sizes, types and state encoding for the tail-pointer RMW controller
package tail_ptr_pkg;
  localparam int NUM_ENTRIES = 21;
  localparam int IDX_W = 5;
  localparam int PTR_W = 6;
  localparam int PTR_MOD = 48;
  localparam int CNT_W = 3;
  localparam logic [PTR_W-1:0] INIT_VAL = '0;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic valid;
    idx_t idx;
    cnt_t cnt;
    ptr_t old;
  } s1_t;
  typedef enum logic [0:0] {INIT = ST_INIT, RUN = ST_RUN} state_e;
  localparam idx_t LAST_IDX = idx_t'(NUM_ENTRIES - 1);
endpackage

// File: rtl/tail_ptr_rmw_ctrl_if.sv
// tail_ptr_rmw_ctrl_if: client request/response, lookup and table port bundle
interface tail_ptr_rmw_ctrl_if;
  import tail_ptr_pkg::*;
  logic clear;
  logic req_valid;
  logic req_ready;
  idx_t req_idx;
  cnt_t req_cnt;
  logic resp_valid;
  idx_t resp_idx;
  ptr_t resp_old;
  ptr_t resp_new;
  logic lookup_en;
  idx_t lookup_idx;
  ptr_t lookup_tail;
  logic init_done;
  idx_t mem_r0_addr;
  logic mem_r0_en;
  ptr_t mem_r0_data;
  idx_t mem_r1_addr;
  logic mem_r1_en;
  ptr_t mem_r1_data;
  idx_t mem_w0_addr;
  logic mem_w0_en;
  ptr_t mem_w0_data;
  modport slave (
    input clear, req_valid, req_idx, req_cnt, lookup_en, lookup_idx, mem_r0_data, mem_r1_data,
    output req_ready, resp_valid, resp_idx, resp_old, resp_new, lookup_tail, init_done,
    output mem_r0_addr, mem_r0_en, mem_r1_addr, mem_r1_en, mem_w0_addr, mem_w0_en, mem_w0_data
  );
  modport master (
    output clear, req_valid, req_idx, req_cnt, lookup_en, lookup_idx, mem_r0_data, mem_r1_data,
    input req_ready, resp_valid, resp_idx, resp_old, resp_new, lookup_tail, init_done,
    input mem_r0_addr, mem_r0_en, mem_r1_addr, mem_r1_en, mem_w0_addr, mem_w0_en, mem_w0_data
  );
endinterface

// File: rtl/tail_ptr_wrap_add.sv
// tail_ptr_wrap_add: combinational tail advance with modulo-PTR_MOD wrap
module tail_ptr_wrap_add
  import tail_ptr_pkg::*;
(
  input  ptr_t old_i,
  input  cnt_t cnt_i,
  output ptr_t new_o
);
  localparam logic [PTR_W:0] MOD = PTR_MOD[PTR_W:0];
  logic [PTR_W:0] sum;
  logic [PTR_W:0] wrapped;
  assign sum = {1'b0, old_i} + {{(PTR_W+1-CNT_W){1'b0}}, cnt_i};
  assign wrapped = sum - MOD;
  assign new_o = (sum >= MOD) ? wrapped[PTR_W-1:0] : sum[PTR_W-1:0];
endmodule

// File: rtl/tail_ptr_rmw_ctrl.sv
// tail_ptr_rmw_ctrl: owns the tail table; init sweep, forwarded RMW advance and lookup
module tail_ptr_rmw_ctrl
  import tail_ptr_pkg::*;
(
  input logic clock,
  input logic reset,
  tail_ptr_rmw_ctrl_if.slave io
);
  state_e state_q, state_d;
  idx_t init_ctr_q, init_ctr_d;
  s1_t s1_q, s1_d;
  idx_t hold_idx_q, hold_idx_d;
  ptr_t hold_old_q, hold_old_d;
  ptr_t hold_new_q, hold_new_d;
  ptr_t s1_new;
  ptr_t old_fwd;
  logic run, accept, init_wr, s1_wr;
  tail_ptr_wrap_add u_add (.old_i(s1_q.old), .cnt_i(s1_q.cnt), .new_o(s1_new));
  assign run = (state_q == RUN) & ~reset;
  assign accept = run & ~io.clear & io.req_valid;
  assign init_wr = (state_q == INIT) & ~reset;
  assign s1_wr = s1_q.valid & ~reset & (s1_q.idx <= LAST_IDX);
  // same-row back-to-back advances must see the value still in flight in S1
  assign old_fwd = (s1_q.valid && s1_q.idx == io.req_idx) ? s1_new : io.mem_r0_data;
  assign io.req_ready = run & ~io.clear;
  assign io.init_done = run;
  assign io.mem_r0_addr = io.req_idx;
  assign io.mem_r0_en = accept;
  assign io.mem_r1_addr = io.lookup_idx;
  assign io.mem_r1_en = run & io.lookup_en;
  assign io.mem_w0_en = init_wr | s1_wr;
  assign io.mem_w0_addr = init_wr ? init_ctr_q : s1_q.idx;
  assign io.mem_w0_data = init_wr ? INIT_VAL : s1_new;
  assign io.resp_valid = s1_q.valid & ~reset;
  assign io.resp_idx = reset ? '0 : s1_q.valid ? s1_q.idx : hold_idx_q;
  assign io.resp_old = reset ? '0 : s1_q.valid ? s1_q.old : hold_old_q;
  assign io.resp_new = reset ? '0 : s1_q.valid ? s1_new : hold_new_q;
  assign io.lookup_tail = reset ? '0 : !run ? INIT_VAL :
                          (s1_q.valid && s1_q.idx == io.lookup_idx) ? s1_new : io.mem_r1_data;
  always_comb begin
    state_d = (state_q == INIT) ? ((init_ctr_q == LAST_IDX) ? RUN : INIT) : (io.clear ? INIT : RUN);
    init_ctr_d = (state_q == INIT) ? init_ctr_q + 1'b1 : '0;
    s1_d = '{valid: accept, idx: io.req_idx, cnt: io.req_cnt, old: old_fwd};
    hold_idx_d = s1_q.valid ? s1_q.idx : hold_idx_q;
    hold_old_d = s1_q.valid ? s1_q.old : hold_old_q;
    hold_new_d = s1_q.valid ? s1_new : hold_new_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      init_ctr_q <= '0;
      s1_q <= '0;
      hold_idx_q <= '0;
      hold_old_q <= '0;
      hold_new_q <= '0;
    end else begin
      state_q <= state_d;
      init_ctr_q <= init_ctr_d;
      s1_q <= s1_d;
      hold_idx_q <= hold_idx_d;
      hold_old_q <= hold_old_d;
      hold_new_q <= hold_new_d;
    end
  end
  assert property (@(posedge clock) accept |-> io.req_idx <= LAST_IDX);
endmodule

// File: tb/tb_tail_ptr_rmw_ctrl.sv
// tb_tail_ptr_rmw_ctrl: directed vectors plus init/clear/reset sequences against a table model
module tb_tail_ptr_rmw_ctrl;
  import tail_ptr_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic preset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  tail_ptr_rmw_ctrl_if bus();
  tail_ptr_rmw_ctrl dut (.clock(clock), .reset(reset), .io(bus));
  logic [PTR_W-1:0] mem [NUM_ENTRIES];
  always @(posedge clock) begin
    if (preset) for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= 6'h2A;
    else if (bus.mem_w0_en && bus.mem_w0_addr < 5'd21) mem[bus.mem_w0_addr] <= bus.mem_w0_data;
  end
  assign bus.mem_r0_data = (bus.mem_r0_addr < 5'd21) ? mem[bus.mem_r0_addr] : '0;
  assign bus.mem_r1_data = (bus.mem_r1_addr < 5'd21) ? mem[bus.mem_r1_addr] : '0;

  typedef struct {
    logic rv;
    int idx;
    int cnt;
    int lidx;
    logic ev;
    int eidx;
    int eold;
    int enew;
    int elk;
  } vec_t;
  vec_t v [25];

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_init(input string nm);
    int k;
    k = 0;
    while (!bus.init_done && k < 40) begin
      cyc();
      k++;
    end
    chk(nm, k, NUM_ENTRIES);
  endtask

  task automatic chk_rows(input string nm);
    for (int i = 0; i < NUM_ENTRIES; i++) chk($sformatf("%s_row%0d", nm, i), int'(mem[i]), 0);
  endtask

  initial begin
    v[0]  = '{1'b0, 0, 0, 3, 1'b0, 0, 0, 0, 0};
    v[1]  = '{1'b1, 3, 5, 3, 1'b0, 0, 0, 0, 0};
    v[2]  = '{1'b0, 0, 0, 3, 1'b1, 3, 0, 5, 5};
    v[3]  = '{1'b0, 0, 0, 3, 1'b0, 3, 0, 5, 5};
    v[4]  = '{1'b1, 7, 7, 7, 1'b0, 3, 0, 5, 0};
    v[5]  = '{1'b1, 7, 7, 7, 1'b1, 7, 0, 7, 7};
    v[6]  = '{1'b1, 7, 7, 7, 1'b1, 7, 7, 14, 14};
    v[7]  = '{1'b1, 7, 7, 7, 1'b1, 7, 14, 21, 21};
    v[8]  = '{1'b1, 7, 7, 7, 1'b1, 7, 21, 28, 28};
    v[9]  = '{1'b1, 7, 7, 7, 1'b1, 7, 28, 35, 35};
    v[10] = '{1'b1, 7, 4, 7, 1'b1, 7, 35, 42, 42};
    v[11] = '{1'b1, 7, 4, 7, 1'b1, 7, 42, 46, 46};
    v[12] = '{1'b0, 0, 0, 7, 1'b1, 7, 46, 2, 2};
    v[13] = '{1'b1, 9, 1, 9, 1'b0, 7, 46, 2, 0};
    v[14] = '{1'b1, 9, 2, 9, 1'b1, 9, 0, 1, 1};
    v[15] = '{1'b1, 9, 3, 9, 1'b1, 9, 1, 3, 3};
    v[16] = '{1'b1, 3, 0, 9, 1'b1, 9, 3, 6, 6};
    v[17] = '{1'b1, 9, 7, 9, 1'b1, 3, 5, 5, 6};
    v[18] = '{1'b1, 9, 7, 9, 1'b1, 9, 6, 13, 13};
    v[19] = '{1'b1, 9, 7, 9, 1'b1, 9, 13, 20, 20};
    v[20] = '{1'b1, 9, 7, 9, 1'b1, 9, 20, 27, 27};
    v[21] = '{1'b1, 9, 7, 9, 1'b1, 9, 27, 34, 34};
    v[22] = '{1'b1, 9, 7, 9, 1'b1, 9, 34, 41, 41};
    v[23] = '{1'b0, 0, 0, 9, 1'b1, 9, 41, 0, 0};
    v[24] = '{1'b0, 0, 0, 9, 1'b0, 9, 41, 0, 0};

    bus.clear = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_idx = 5'd3;
    bus.req_cnt = 3'd1;
    bus.lookup_en = 1'b1;
    bus.lookup_idx = 5'd3;
    cyc();
    preset = 1'b0;
    cyc();
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_init_done", int'(bus.init_done), 0);
    chk("rst_w0_en", int'(bus.mem_w0_en), 0);
    chk("rst_r0_en", int'(bus.mem_r0_en), 0);
    chk("rst_r1_en", int'(bus.mem_r1_en), 0);
    chk("rst_resp_idx", int'(bus.resp_idx), 0);
    chk("rst_resp_old", int'(bus.resp_old), 0);
    chk("rst_resp_new", int'(bus.resp_new), 0);
    chk("rst_lookup", int'(bus.lookup_tail), 0);
    reset = 1'b0;
    #1;
    chk("init0_w0_en", int'(bus.mem_w0_en), 1);
    chk("init0_w0_addr", int'(bus.mem_w0_addr), 0);
    chk("init0_w0_data", int'(bus.mem_w0_data), 0);
    chk("init0_req_ready", int'(bus.req_ready), 0);
    chk("init0_lookup", int'(bus.lookup_tail), 0);
    bus.req_valid = 1'b0;
    wait_init("init_after_reset");
    chk_rows("swept");

    for (int i = 0; i < 25; i++) begin
      bus.req_valid = v[i].rv;
      bus.req_idx = 5'(v[i].idx);
      bus.req_cnt = 3'(v[i].cnt);
      bus.lookup_idx = 5'(v[i].lidx);
      #1;
      chk($sformatf("v%0d_ready", i), int'(bus.req_ready), 1);
      chk($sformatf("v%0d_resp_valid", i), int'(bus.resp_valid), int'(v[i].ev));
      chk($sformatf("v%0d_resp_idx", i), int'(bus.resp_idx), v[i].eidx);
      chk($sformatf("v%0d_resp_old", i), int'(bus.resp_old), v[i].eold);
      chk($sformatf("v%0d_resp_new", i), int'(bus.resp_new), v[i].enew);
      chk($sformatf("v%0d_lookup", i), int'(bus.lookup_tail), v[i].elk);
      cyc();
    end

    bus.req_valid = 1'b1;
    bus.req_idx = 5'd2;
    bus.req_cnt = 3'd3;
    bus.lookup_idx = 5'd2;
    #1;
    chk("clr_a_ready", int'(bus.req_ready), 1);
    cyc();
    bus.clear = 1'b1;
    bus.req_cnt = 3'd1;
    #1;
    chk("clr_b_ready", int'(bus.req_ready), 0);
    chk("clr_b_r0_en", int'(bus.mem_r0_en), 0);
    chk("clr_b_resp_valid", int'(bus.resp_valid), 1);
    chk("clr_b_resp_idx", int'(bus.resp_idx), 2);
    chk("clr_b_resp_old", int'(bus.resp_old), 0);
    chk("clr_b_resp_new", int'(bus.resp_new), 3);
    chk("clr_b_w0_en", int'(bus.mem_w0_en), 1);
    chk("clr_b_w0_addr", int'(bus.mem_w0_addr), 2);
    chk("clr_b_w0_data", int'(bus.mem_w0_data), 3);
    chk("clr_b_lookup", int'(bus.lookup_tail), 3);
    cyc();
    bus.clear = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("clr_c_resp_valid", int'(bus.resp_valid), 0);
    chk("clr_c_ready", int'(bus.req_ready), 0);
    chk("clr_c_init_done", int'(bus.init_done), 0);
    chk("clr_c_w0_addr", int'(bus.mem_w0_addr), 0);
    chk("clr_c_resp_new_held", int'(bus.resp_new), 3);
    wait_init("init_after_clear");
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      bus.lookup_idx = 5'(i);
      #1;
      chk($sformatf("clr_lookup_row%0d", i), int'(bus.lookup_tail), 0);
    end
    cyc();

    bus.req_valid = 1'b1;
    bus.req_idx = 5'd15;
    bus.req_cnt = 3'd5;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    chk("row15_written", int'(mem[15]), 5);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    repeat (10) cyc();
    #1;
    chk("mid_init_w0_addr", int'(bus.mem_w0_addr), 10);
    reset = 1'b1;
    #1;
    chk("mid_init_rst_w0_en", int'(bus.mem_w0_en), 0);
    chk("mid_init_rst_init_done", int'(bus.init_done), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("restart_w0_addr", int'(bus.mem_w0_addr), 0);
    wait_init("init_after_mid_reset");
    chk_rows("reswept");

    bus.req_valid = 1'b1;
    bus.req_idx = 5'd4;
    bus.req_cnt = 3'd2;
    cyc();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("run_rst_resp_valid", int'(bus.resp_valid), 0);
    chk("run_rst_w0_en", int'(bus.mem_w0_en), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("run_rst_after_resp_valid", int'(bus.resp_valid), 0);
    wait_init("init_after_run_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
